// File: rtl/bus_tenure_arbiter_pkg.sv
// Shared definitions for the bus tenure arbiter and related bus arbiters.
package bus_tenure_arbiter_pkg;

    localparam int MAX_CORES          = 4;
    localparam int TENURE_MAX_DEFAULT = 256;

    typedef enum logic [1:0] {
        ARB_IDLE  = 2'b00,
        ARB_GRANT = 2'b01,
        ARB_TURN  = 2'b10
    } arb_state_e;

endpackage

// File: rtl/rr_priority_picker.sv
// Combinational circular priority encoder: picks the first requester at or
// above the pointer, wrapping from N-1 back to 0.
module rr_priority_picker #(
    parameter int N = 4,
    parameter int W = 2
) (
    input  logic [N-1:0] req,
    input  logic [W-1:0] ptr,
    output logic [W-1:0] winner,
    output logic         valid
);
    import bus_tenure_arbiter_pkg::*;

    // Scan offsets from farthest to nearest so the nearest requester wins.
    always_comb begin
        winner = '0;
        valid  = 1'b0;
        for (int off = N - 1; off >= 0; off--) begin
            winner = req[(int'(ptr) + off) % N] ? W'((int'(ptr) + off) % N) : winner;
            valid  = valid | req[(int'(ptr) + off) % N];
        end
    end

endmodule

// File: rtl/bus_tenure_arbiter.sv
// Registered round-robin bus arbiter with tenure limit, preemption and a
// one-cycle turnaround between owners.
module bus_tenure_arbiter #(
    parameter int MAX_CORES  = bus_tenure_arbiter_pkg::MAX_CORES,
    parameter int SEL_W      = 2,
    parameter int TENURE_MAX = bus_tenure_arbiter_pkg::TENURE_MAX_DEFAULT,
    parameter int TEN_W      = 9
) (
    input  logic                 Clock,
    input  logic                 Reset,
    input  logic [MAX_CORES-1:0] iRequest,
    output logic [MAX_CORES-1:0] oGrant,
    output logic [SEL_W-1:0]     oBusSelect,
    output logic                 oBusBusy,
    output logic                 oTimeout
);
    import bus_tenure_arbiter_pkg::*;

    localparam logic [SEL_W-1:0] LAST_IDX   = SEL_W'(MAX_CORES - 1);
    localparam logic [TEN_W-1:0] TEN_LIMIT  = TEN_W'(TENURE_MAX);
    localparam logic [TEN_W-1:0] TEN_PRE    = TEN_W'((TENURE_MAX == 0) ? 0 : (TENURE_MAX - 1));
    localparam bit               PREEMPT_EN = (TENURE_MAX != 0);

    arb_state_e             state_r, state_s;
    logic [MAX_CORES-1:0]   grant_r, grant_s;
    logic [SEL_W-1:0]       sel_r, sel_s;
    logic                   busy_r, busy_s;
    logic                   timeout_r, timeout_s;
    logic [SEL_W-1:0]       ptr_r, ptr_s;
    logic [TEN_W-1:0]       tenure_r, tenure_s;
    logic [SEL_W-1:0]       winner_s;
    logic                   valid_s;
    logic                   owner_req_s;
    logic                   others_req_s;
    logic [SEL_W-1:0]       ptr_after_owner_s;

    function automatic logic [MAX_CORES-1:0] to_onehot(input logic [SEL_W-1:0] idx);
        logic [MAX_CORES-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    rr_priority_picker #(
        .N (MAX_CORES),
        .W (SEL_W)
    ) u_picker (
        .req    (iRequest),
        .ptr    (ptr_r),
        .winner (winner_s),
        .valid  (valid_s)
    );

    // The registered grant is the owner's one-hot mask, so it splits the
    // request vector into "owner still wants the bus" and "someone else waits".
    always_comb begin
        owner_req_s       = |(iRequest & grant_r);
        others_req_s      = |(iRequest & ~grant_r);
        ptr_after_owner_s = (sel_r == LAST_IDX) ? '0 : (sel_r + SEL_W'(1));
    end

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_s   = state_r;
        grant_s   = grant_r;
        sel_s     = sel_r;
        busy_s    = busy_r;
        timeout_s = 1'b0;
        ptr_s     = ptr_r;
        tenure_s  = tenure_r;
        case (state_r)
            ARB_IDLE, ARB_TURN: begin
                if (valid_s) begin
                    state_s  = ARB_GRANT;
                    grant_s  = to_onehot(winner_s);
                    sel_s    = winner_s;
                    busy_s   = 1'b1;
                    tenure_s = '0;
                end else begin
                    state_s = ARB_IDLE;
                    grant_s = '0;
                    busy_s  = 1'b0;
                end
            end
            ARB_GRANT: begin
                if (!owner_req_s) begin
                    // Release wins over an expiring tenure: no timeout pulse.
                    state_s = ARB_TURN;
                    grant_s = '0;
                    busy_s  = 1'b0;
                    ptr_s   = ptr_after_owner_s;
                end else if (PREEMPT_EN && (tenure_r >= TEN_PRE) && others_req_s) begin
                    // >= so a requester arriving after saturation still preempts.
                    state_s   = ARB_TURN;
                    grant_s   = '0;
                    busy_s    = 1'b0;
                    ptr_s     = ptr_after_owner_s;
                    timeout_s = 1'b1;
                end else begin
                    tenure_s = (tenure_r == TEN_LIMIT) ? tenure_r : (tenure_r + TEN_W'(1));
                end
            end
            default: begin
                state_s = ARB_IDLE;
                grant_s = '0;
                busy_s  = 1'b0;
            end
        endcase
    end

    // State, pointer, counter and output registers; reset clears the grant at once.
    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_r   <= ARB_IDLE;
            grant_r   <= '0;
            sel_r     <= '0;
            busy_r    <= 1'b0;
            timeout_r <= 1'b0;
            ptr_r     <= '0;
            tenure_r  <= '0;
        end else begin
            state_r   <= state_s;
            grant_r   <= grant_s;
            sel_r     <= sel_s;
            busy_r    <= busy_s;
            timeout_r <= timeout_s;
            ptr_r     <= ptr_s;
            tenure_r  <= tenure_s;
        end
    end

    assign oGrant     = grant_r;
    assign oBusSelect = sel_r;
    assign oBusBusy   = busy_r;
    assign oTimeout   = timeout_r;

endmodule
